// File: rtl/fetch_unit_if.sv
// rtl/fetch_unit_if.sv - fetch stage bus: imem request/response, redirect and instruction channels
interface fetch_unit_if;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr_data;
    logic [31:0] instr_pc;

    modport master (
        output imem_req_valid,
        output imem_req_addr,
        input  imem_req_ready,
        input  imem_rsp_valid,
        input  imem_rsp_data,
        input  redirect_valid,
        input  redirect_pc,
        output instr_valid,
        output instr_data,
        output instr_pc,
        input  instr_ready
    );

    modport slave (
        input  imem_req_valid,
        input  imem_req_addr,
        output imem_req_ready,
        output imem_rsp_valid,
        output imem_rsp_data,
        output redirect_valid,
        output redirect_pc,
        input  instr_valid,
        input  instr_data,
        input  instr_pc,
        output instr_ready
    );
endinterface

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage with PC-tagged response queue and redirect flush
// Optional FETCH_BYPASS_EN: a response arriving at an empty queue goes to execute in the same cycle.
module fetch_unit #(
    parameter int          DEPTH    = 2,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic         clk,
    input  logic         reset,
    fetch_unit_if.master bus
);
    localparam int          CW      = $clog2(DEPTH + 1);
    localparam int          PW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [31:0] NOP     = 32'h0000_0013;
    localparam logic [CW:0] CREDITS = (CW + 1)'(DEPTH);

    logic [31:0]   fetch_pc;
    logic [31:0]   last_pc;
    logic [31:0]   q_pc   [DEPTH];
    logic [31:0]   q_data [DEPTH];
    logic [31:0]   tag_pc [DEPTH];
    logic [PW-1:0] q_head, q_tail, t_head, t_tail;
    logic [CW-1:0] count, outstanding, drop;

    logic          q_nonempty;
    logic [CW:0]   credit_used;
    logic          req_fire, rsp_keep, bypass, enq, deq;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        q_nonempty  = (count != '0);
        // Credits cover both in-flight and buffered entries, so every response has a queue slot.
        credit_used = {1'b0, outstanding} + {1'b0, count};

        bus.imem_req_valid = !reset && !bus.redirect_valid && (credit_used < CREDITS);
        bus.imem_req_addr  = fetch_pc;
        req_fire           = bus.imem_req_valid && bus.imem_req_ready;
        rsp_keep           = bus.imem_rsp_valid && (drop == '0) && !bus.redirect_valid;

`ifdef FETCH_BYPASS_EN
        bypass = rsp_keep && !q_nonempty && bus.instr_ready;
`else
        bypass = 1'b0;
`endif
        enq = rsp_keep && !bypass;
        deq = q_nonempty && bus.instr_ready && !bus.redirect_valid;

        bus.instr_valid = !bus.redirect_valid && (q_nonempty || bypass);
        if (q_nonempty) begin
            bus.instr_data = q_data[q_head];
            bus.instr_pc   = q_pc[q_head];
        end else begin
            bus.instr_data = NOP;
            bus.instr_pc   = last_pc;
`ifdef FETCH_BYPASS_EN
            if (bypass) begin
                bus.instr_data = bus.imem_rsp_data;
                bus.instr_pc   = tag_pc[t_head];
            end
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc    <= RESET_PC;
            last_pc     <= '0;
            q_head      <= '0;
            q_tail      <= '0;
            t_head      <= '0;
            t_tail      <= '0;
            count       <= '0;
            outstanding <= '0;
            drop        <= '0;
        end else begin
            if (q_nonempty) begin
                last_pc <= q_pc[q_head];
            end else if (bypass) begin
                last_pc <= tag_pc[t_head];
            end

            if (bus.redirect_valid) begin
                // Everything still in memory is wrong-path; a response landing now is already discarded.
                fetch_pc    <= bus.redirect_pc & 32'hFFFF_FFFC;
                q_head      <= '0;
                q_tail      <= '0;
                t_head      <= '0;
                t_tail      <= '0;
                count       <= '0;
                outstanding <= outstanding - CW'(bus.imem_rsp_valid);
                drop        <= outstanding - CW'(bus.imem_rsp_valid);
            end else begin
                if (req_fire) begin
                    t_tail   <= ptr_inc(t_tail);
                    fetch_pc <= fetch_pc + 32'd4;
                end
                if (rsp_keep) begin
                    t_head <= ptr_inc(t_head);
                end
                if (bus.imem_rsp_valid && (drop != '0)) begin
                    drop <= drop - 1'b1;
                end
                outstanding <= outstanding + CW'(req_fire) - CW'(bus.imem_rsp_valid);
                if (enq) begin
                    q_tail <= ptr_inc(q_tail);
                end
                if (deq) begin
                    q_head <= ptr_inc(q_head);
                end
                count <= count + CW'(enq) - CW'(deq);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (req_fire) begin
            tag_pc[t_tail] <= fetch_pc;
        end
        if (enq) begin
            q_pc[q_tail]   <= tag_pc[t_head];
            q_data[q_tail] <= bus.imem_rsp_data;
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed and randomized bench for fetch_unit against a program-order reference model
module tb_fetch_unit;
    localparam int          DEPTH    = 2;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP      = 32'h0000_0013;
`ifdef FETCH_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    fetch_unit_if bus ();

    fetch_unit #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int lat    = 1;
    logic [31:0] seed_word;

    // memory: in-order pending requests with due cycle and wrong-path marker
    logic [31:0] mq_addr  [$];
    int          mq_due   [$];
    bit          mq_stale [$];

    // program-order model: next PC to deliver, next PC to request, responses waiting for execute
    logic [31:0] exp_pc, exp_req, shown_pc;
    int          buffered;
    bit          prev_rst;

    bit          obs_rv, obs_iv, obs_req_fire, obs_ins_fire;
    logic [31:0] obs_addr, obs_pc, obs_data;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ seed_word;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        assert (got === want) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, got, want);
        end
    endtask

    task automatic step(input bit do_rst, input bit redir, input logic [31:0] tgt,
                        input bit rq_rdy, input bit in_rdy);
        bit          rsp, stale, byp, exp_rv, exp_iv;
        logic [31:0] rsp_addr;
        int          due;
        @(negedge clk);
        rsp      = !do_rst && (mq_addr.size() > 0) && (mq_due[0] <= cyc);
        rsp_addr = rsp ? mq_addr[0] : 32'h0;
        reset              = do_rst;
        bus.redirect_valid = redir && !do_rst;
        bus.redirect_pc    = tgt;
        bus.imem_req_ready = rq_rdy;
        bus.instr_ready    = in_rdy && !do_rst;
        bus.imem_rsp_valid = rsp;
        bus.imem_rsp_data  = rsp ? mem_word(rsp_addr) : $urandom();
        #1;
        obs_rv       = bus.imem_req_valid;
        obs_addr     = bus.imem_req_addr;
        obs_iv       = bus.instr_valid;
        obs_pc       = bus.instr_pc;
        obs_data     = bus.instr_data;
        obs_req_fire = obs_rv && rq_rdy;
        obs_ins_fire = obs_iv && bus.instr_ready;
        if (do_rst) begin
            chk("req_valid_in_reset", 32'(obs_rv), 32'd0);
            if (prev_rst) begin
                chk("reset_instr_valid", 32'(obs_iv), 32'd0);
                chk("reset_instr_data", obs_data, NOP);
                chk("reset_instr_pc", obs_pc, 32'd0);
                chk("reset_req_addr", obs_addr, RESET_PC);
            end
            mq_addr.delete();
            mq_due.delete();
            mq_stale.delete();
            exp_pc   = RESET_PC;
            exp_req  = RESET_PC;
            shown_pc = 32'd0;
            buffered = 0;
        end else begin
            stale  = rsp && (mq_stale[0] || redir);
            byp    = BYP && rsp && !stale && (buffered == 0) && in_rdy;
            exp_rv = !redir && (mq_addr.size() + buffered < DEPTH);
            exp_iv = !redir && ((buffered > 0) || byp);
            chk("req_valid", 32'(obs_rv), 32'(exp_rv));
            if (exp_rv) chk("req_addr", obs_addr, exp_req);
            chk("instr_valid", 32'(obs_iv), 32'(exp_iv));
            if ((buffered > 0) || byp) begin
                if (exp_iv) begin
                    chk("instr_pc", obs_pc, exp_pc);
                    chk("instr_data", obs_data, mem_word(exp_pc));
                end
                shown_pc = exp_pc;
            end else begin
                chk("empty_data_nop", obs_data, NOP);
                chk("empty_pc_hold", obs_pc, shown_pc);
            end
            if (rsp) begin
                void'(mq_addr.pop_front());
                void'(mq_due.pop_front());
                void'(mq_stale.pop_front());
                if (!stale && !byp) buffered++;
            end
            if (exp_iv && in_rdy) begin
                exp_pc += 32'd4;
                if (!byp) buffered--;
            end
            if (exp_rv && rq_rdy) begin
                due = cyc + lat;
                if ((mq_due.size() > 0) && (due <= mq_due[$])) due = mq_due[$] + 1;
                mq_addr.push_back(exp_req);
                mq_due.push_back(due);
                mq_stale.push_back(1'b0);
                exp_req += 32'd4;
            end
            if (redir) begin
                foreach (mq_stale[i]) mq_stale[i] = 1'b1;
                buffered = 0;
                exp_pc   = tgt & 32'hFFFF_FFFC;
                exp_req  = tgt & 32'hFFFF_FFFC;
            end
        end
        prev_rst = do_rst;
        cyc++;
    endtask

    task automatic do_reset();
        step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    endtask

    initial begin
        logic [31:0] got [3];
        logic [31:0] first_addr, first_pc;
        int          first_req, first_iv, n, nreq;
        bit          found, saw, have_req, have_pc;

        seed_word          = $urandom();
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 32'h0;
        bus.imem_req_ready = 1'b0;
        bus.instr_ready    = 1'b0;
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = 32'h0;

        // reset release with 1-cycle memory and execute always ready
        do_reset();
        lat = 1;
        first_req = -1;
        first_iv  = -1;
        n = 0;
        for (int i = 0; i < 12; i++) begin
            step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
            if (obs_req_fire && first_req < 0) first_req = i;
            if (obs_iv && first_iv < 0) first_iv = i;
            if (obs_ins_fire && n < 3) begin
                got[n] = obs_pc;
                n++;
            end
        end
        chk("first_req_cycle", first_req, 0);
        chk("first_valid_latency", first_iv - first_req, BYP ? 1 : 2);
        chk("seq_pc0", got[0], 32'h0);
        chk("seq_pc1", got[1], 32'h4);
        chk("seq_pc2", got[2], 32'h8);

        // execute stalled: credits stop issue at DEPTH
        do_reset();
        nreq = 0;
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
            if (obs_req_fire) nreq++;
        end
        chk("stall_req_count", nreq, DEPTH);
        chk("stall_req_valid_low", 32'(obs_rv), 32'd0);
        n = 0;
        got[0] = 'x;
        got[1] = 'x;
        for (int i = 0; i < 6; i++) begin
            step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
            if (obs_ins_fire && n < 2) begin
                got[n] = obs_pc;
                n++;
            end
        end
        chk("release_pc0", got[0], 32'h0);
        chk("release_pc1", got[1], 32'h4);

        // memory not ready: address holds
        do_reset();
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
            chk("hold_addr", obs_addr, RESET_PC);
        end
        step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
        chk("hold_then_fire", 32'(obs_req_fire), 32'd1);
        chk("hold_then_addr", obs_addr, RESET_PC);

        // redirect with 0x8 and 0xC in flight
        do_reset();
        lat = 2;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            if (mq_addr.size() == 2 && mq_addr[0] == 32'h8 && mq_addr[1] == 32'hC
                && !mq_stale[0] && !mq_stale[1] && buffered == 0)
                found = 1'b1;
            else
                step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
        end
        chk("two_in_flight_reached", 32'(found), 32'd1);
        step(1'b0, 1'b1, 32'h0000_0103, 1'b1, 1'b1);
        chk("redirect_req_low", 32'(obs_rv), 32'd0);
        chk("redirect_instr_low", 32'(obs_iv), 32'd0);
        have_req = 1'b0;
        have_pc  = 1'b0;
        first_addr = 'x;
        first_pc   = 'x;
        for (int i = 0; i < 20; i++) begin
            step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
            if (obs_req_fire && !have_req) begin
                first_addr = obs_addr;
                have_req = 1'b1;
            end
            if (obs_ins_fire && !have_pc) begin
                first_pc = obs_pc;
                have_pc = 1'b1;
            end
        end
        chk("redirect_first_req", first_addr, 32'h100);
        chk("redirect_first_pc", first_pc, 32'h100);

        // redirect while 0x10 is buffered and execute ready
        do_reset();
        lat = 1;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            if (buffered > 0 && exp_pc == 32'h10)
                found = 1'b1;
            else
                step(1'b0, 1'b0, 32'h0, 1'b1, exp_pc != 32'h10);
        end
        chk("buffered_0x10_reached", 32'(found), 32'd1);
        step(1'b0, 1'b1, 32'h0000_0200, 1'b1, 1'b1);
        chk("redirect_blocks_transfer", 32'(obs_ins_fire), 32'd0);
        saw = 1'b0;
        for (int i = 0; i < 12; i++) begin
            step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
            if (obs_ins_fire && obs_pc == 32'h10) saw = 1'b1;
        end
        chk("wrong_path_never_delivered", 32'(saw), 32'd0);

        // reset with a full queue
        do_reset();
        for (int i = 0; i < 20 && buffered < DEPTH; i++)
            step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        chk("full_queue_valid", 32'(obs_iv), 32'd1);
        chk("full_queue_no_req", 32'(obs_rv), 32'd0);
        step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
        chk("post_reset_valid", 32'(obs_iv), 32'd0);
        chk("post_reset_data", obs_data, NOP);
        chk("post_reset_fetch", obs_addr, RESET_PC);

        // randomized traffic at several memory latencies
        for (int ph = 0; ph < 3; ph++) begin
            do_reset();
            lat = 1 + ph;
            for (int i = 0; i < 400; i++) begin
                step(1'b0, $urandom_range(99) < 4, $urandom(),
                     $urandom_range(99) < 75, $urandom_range(99) < 70);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
